// File: rtl/fp_pkg.sv
// Shared FP datapath definitions: IEEE-754 single field widths, special
// encodings and the 2-bit exception class used by the FP flag logic.
package fp_pkg;

  localparam int FP_WIDTH = 32;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;

  localparam logic [EXP_W-1:0]    EXP_ALL_ONES = 8'hFF;
  localparam logic [FP_WIDTH-1:0] FP_QNAN      = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    EXC_NONE = 2'b00,
    EXC_INF  = 2'b01,
    EXC_NAN  = 2'b10,
    EXC_RSVD = 2'b11
  } exc_t;

  // Classify a single-precision value as Inf, NaN or ordinary.
  function automatic exc_t fp_classify(input logic [FP_WIDTH-1:0] v);
    exc_t r;
    if (v[FP_WIDTH-2 -: EXP_W] != EXP_ALL_ONES) begin
      r = EXC_NONE;
    end else if (v[MAN_W-1:0] == {MAN_W{1'b0}}) begin
      r = EXC_INF;
    end else begin
      r = EXC_NAN;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_result_collector_chk.sv
// Invariant checker for the result collector: the credit scheme must make
// it impossible to push into a full FIFO or to overspend credits.
module fp_result_collector_chk #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input logic             clk,
  input logic             rst,
  input logic             push,
  input logic [CNT_W-1:0] count,
  input logic [CNT_W-1:0] used
);

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst) !(push && (count == CNT_W'(DEPTH)))
  );

  a_credit_bound: assert property (
    @(posedge clk) disable iff (!rst) (used <= CNT_W'(DEPTH))
  );

endmodule

// File: rtl/fp_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count. Fullness and emptiness
// come from the counter; pointers simply wrap modulo DEPTH (power of two).
// The head output reads as zero while the FIFO is empty.
module fp_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic             empty_s;

  // Qualify push/pop against the current occupancy.
  always_comb begin
    empty_s   = (count_r == {CNT_W{1'b0}});
    push_ok_s = push && (count_r != CNT_W'(DEPTH));
    pop_ok_s  = pop && !empty_s;
  end

  // Storage array; contents need no reset because the head is gated by count.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Show-ahead head presentation.
  always_comb begin
    head_data = empty_s ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
    count     = count_r;
  end

endmodule

// File: rtl/fp_result_collector.sv
// Result collector behind the fixed-latency FP datapath g = (a+b)*c - d.
// A tag line tracks accepted operand sets through the datapath; a set tag
// leaving the line captures dp_g into an output FIFO. Credits (FIFO
// occupancy plus tags in flight) gate in_ready so no result is dropped.
// Optional: define FP_RESULT_EXC_EN to store and present a per-entry
// Inf/NaN class on out_exc.
module fp_result_collector
  import fp_pkg::*;
#(
  parameter int DP_LATENCY = 6,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FP_WIDTH-1:0] dp_g,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FP_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]    out_count
`ifdef FP_RESULT_EXC_EN
  ,
  output logic [1:0]          out_exc
`endif
);

`ifdef FP_RESULT_EXC_EN
  localparam int ENTRY_W = FP_WIDTH + 2;
`else
  localparam int ENTRY_W = FP_WIDTH;
`endif

  logic [DP_LATENCY-1:0] tag_r;
  logic [DP_LATENCY-1:0] tag_s;
  logic [CNT_W-1:0]      used_r;
  logic [CNT_W-1:0]      used_s;
  logic                  in_ready_r;
  logic                  accept_s;
  logic                  push_s;
  logic                  pop_s;
  logic [ENTRY_W-1:0]    push_entry_s;
  logic [ENTRY_W-1:0]    head_entry_s;
  logic [CNT_W-1:0]      fifo_count_s;

  // Handshake decode, tag line advance and credit update.
  always_comb begin
    accept_s  = in_valid && in_ready_r;
    push_s    = tag_r[DP_LATENCY-1];
    pop_s     = out_valid && out_ready;
    tag_s     = (tag_r << 1) | DP_LATENCY'(accept_s);
    case ({accept_s, pop_s})
      2'b10:   used_s = used_r + CNT_W'(1);
      2'b01:   used_s = used_r - CNT_W'(1);
      default: used_s = used_r;
    endcase
  end

  // Tag line shifts every cycle; credits and in_ready are registered so
  // in_ready never depends combinationally on out_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_r      <= {DP_LATENCY{1'b0}};
      used_r     <= {CNT_W{1'b0}};
      in_ready_r <= 1'b1;
    end else begin
      tag_r      <= tag_s;
      used_r     <= used_s;
      in_ready_r <= (used_s < CNT_W'(DEPTH));
    end
  end

  // Build the captured entry (result plus optional class).
  always_comb begin
`ifdef FP_RESULT_EXC_EN
    push_entry_s = {fp_classify(dp_g), dp_g};
`else
    push_entry_s = dp_g;
`endif
  end

  fp_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head_data (head_entry_s),
    .count     (fifo_count_s)
  );

  // Output presentation from registered FIFO state.
  always_comb begin
    in_ready  = in_ready_r;
    out_count = fifo_count_s;
    out_valid = (fifo_count_s != {CNT_W{1'b0}});
    out_data  = head_entry_s[FP_WIDTH-1:0];
`ifdef FP_RESULT_EXC_EN
    out_exc   = head_entry_s[ENTRY_W-1 -: 2];
`endif
  end

  fp_result_collector_chk #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .count (fifo_count_s),
    .used  (used_r)
  );

endmodule

// File: tb/tb_fp_result_collector.sv
// Directed bench for fp_result_collector with a fixed-latency datapath stub.
module tb_fp_result_collector;
  import fp_pkg::*;

  localparam int DP_LATENCY = 6;
  localparam int DEPTH      = 8;
  localparam int CNT_W      = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      dp_g;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;
`ifdef FP_RESULT_EXC_EN
  logic [1:0]       out_exc;
`endif

  logic [31:0] op_a, op_b, op_c, op_d;
  logic [31:0] dp_pipe [DP_LATENCY];
  logic [31:0] exp_q [$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_result_collector #(
    .DP_LATENCY (DP_LATENCY),
    .DEPTH      (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dp_g      (dp_g),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
`ifdef FP_RESULT_EXC_EN
    ,
    .out_exc   (out_exc)
`endif
  );

  // Hand-computed g = (a+b)*c - d for the directed vectors used here.
  function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && c == 32'h4080_0000 && d == 32'h4000_0000)
      return 32'h4120_0000;
    if (a == 32'h7F80_0000 && b == 32'hFF80_0000)
      return FP_QNAN;
    if (a == 32'h7F00_0000 && b == 32'h7F00_0000 && c == 32'h4000_0000 && d == 32'h0000_0000)
      return 32'h7F80_0000;
    if (b == 32'h0000_0000 && c == 32'h3F80_0000 && d == 32'h0000_0000)
      return a;
    return 32'hBAD0_0000 ^ a;
  endfunction

  // Datapath stand-in: DP_LATENCY register stages, never stalls, never reset.
  always @(posedge clk) begin
    dp_pipe[0] <= in_valid ? fp_ref(op_a, op_b, op_c, op_d) : 32'hDEAD_BEEF;
    for (int i = 1; i < DP_LATENCY; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign dp_g = dp_pipe[DP_LATENCY-1];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: verify any pop against the scoreboard, then record any accept.
  task automatic cycle(input string tag, output logic acc);
    logic rdy;
    rdy = in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check_val({tag, "_spurious"}, 32'(out_valid), 32'd0);
      else check_val({tag, "_data"}, out_data, exp_q.pop_front());
    end
    @(posedge clk);
    acc = in_valid && rdy;
    if (acc) exp_q.push_back(fp_ref(op_a, op_b, op_c, op_d));
    @(negedge clk);
  endtask

  task automatic run(input string tag, input int n, input logic bump);
    logic acc;
    for (int i = 0; i < n; i++) begin
      cycle(tag, acc);
      if (acc && bump) op_a = op_a + 32'd1;
    end
  endtask

  task automatic set_pass_op(input logic [31:0] a);
    op_a = a; op_b = 32'h0000_0000; op_c = 32'h3F80_0000; op_d = 32'h0000_0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int n, nacc, stale;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = 32'd0; op_b = 32'd0; op_c = 32'd0; op_d = 32'd0;
    @(negedge clk); @(negedge clk);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_count", 32'(out_count), 32'd0);
    check_val("rst_out_data", out_data, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);

    // Single op: 1.0, 2.0, 4.0, 2.0 -> 10.0
    out_ready = 1'b1;
    op_a = 32'h3F80_0000; op_b = 32'h4000_0000; op_c = 32'h4080_0000; op_d = 32'h4000_0000;
    in_valid = 1'b1;
    cycle("single", acc);
    in_valid = 1'b0;
    check_val("single_acc", 32'(acc), 32'd1);
    n = 1;
    while (!out_valid && n < 20) begin cycle("single", acc); n++; end
    check_val("single_latency", 32'(n), 32'(DP_LATENCY + 1));
    check_val("single_value", out_data, 32'h4120_0000);
`ifdef FP_RESULT_EXC_EN
    check_val("single_exc", 32'(out_exc), 32'd0);
`endif
    cycle("single", acc);
    check_val("single_pulse", 32'(out_valid), 32'd0);
    check_val("single_count", 32'(out_count), 32'd0);

    // Back-pressure: consumer stalled, source always valid.
    out_ready = 1'b0;
    set_pass_op(32'h4000_0000);
    in_valid = 1'b1;
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      cycle("bp", acc);
      if (acc) begin nacc++; op_a = op_a + 32'd1; end
    end
    check_val("bp_accepts", 32'(nacc), 32'd8);
    check_val("bp_ready_low", 32'(in_ready), 32'd0);
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      cycle("bp", acc);
      if (acc) nacc++;
    end
    check_val("bp_extra_accepts", 32'(nacc), 32'd0);
    in_valid = 1'b0;
    run("bp", 4, 1'b0);
    check_val("bp_count_full", 32'(out_count), 32'd8);
    check_val("bp_ready_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    check_val("bp_ready_nocomb", 32'(in_ready), 32'd0);
    cycle("bp", acc);
    check_val("bp_ready_back", 32'(in_ready), 32'd1);
    run("bp", 10, 1'b0);
    check_val("bp_drained", 32'(exp_q.size()), 32'd0);
    check_val("bp_count_empty", 32'(out_count), 32'd0);

    // Streaming: both sides always ready for 100 cycles.
    set_pass_op(32'h3F00_0000);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      check_val("stream_ready", 32'(in_ready), 32'd1);
      check_val("stream_count_le1", 32'(out_count <= CNT_W'(1)), 32'd1);
      cycle("stream", acc);
      if (acc) op_a = op_a + 32'd1;
    end
    in_valid = 1'b0;
    run("stream", 12, 1'b0);
    check_val("stream_drained", 32'(exp_q.size()), 32'd0);

    // Simultaneous accept + pop at used = DEPTH-1.
    out_ready = 1'b0;
    set_pass_op(32'h4100_0000);
    in_valid = 1'b1;
    run("simul", 7, 1'b1);
    in_valid = 1'b0;
    run("simul", 8, 1'b0);
    check_val("simul_count7", 32'(out_count), 32'd7);
    in_valid = 1'b1; out_ready = 1'b1;
    check_val("simul_ready_pre", 32'(in_ready), 32'd1);
    cycle("simul", acc);
    if (acc) op_a = op_a + 32'd1;
    check_val("simul_both_acc", 32'(acc), 32'd1);
    in_valid = 1'b0; out_ready = 1'b0;
    check_val("simul_ready_post", 32'(in_ready), 32'd1);
    check_val("simul_count6", 32'(out_count), 32'd6);
    run("simul", 8, 1'b0);
    check_val("simul_count_back7", 32'(out_count), 32'd7);
    in_valid = 1'b1;
    check_val("simul_last_credit", 32'(in_ready), 32'd1);
    cycle("simul", acc);
    if (acc) op_a = op_a + 32'd1;
    in_valid = 1'b0;
    check_val("simul_now_full", 32'(in_ready), 32'd0);
    run("simul", 8, 1'b0);
    check_val("simul_count8", 32'(out_count), 32'd8);
    out_ready = 1'b1;
    run("simul", 12, 1'b0);
    check_val("simul_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-flight: 2 entries in the FIFO, 3 tags in the tag line.
    out_ready = 1'b0;
    set_pass_op(32'h4200_0000);
    in_valid = 1'b1;
    run("midrst", 2, 1'b1);
    in_valid = 1'b0;
    run("midrst", 8, 1'b0);
    check_val("midrst_count2", 32'(out_count), 32'd2);
    in_valid = 1'b1;
    run("midrst", 3, 1'b1);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_val("midrst_valid", 32'(out_valid), 32'd0);
    check_val("midrst_count", 32'(out_count), 32'd0);
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) stale++;
      cycle("midrst", acc);
    end
    check_val("midrst_no_stale", 32'(stale), 32'd0);
    check_val("midrst_ready", 32'(in_ready), 32'd1);

    // Post-reset sanity op.
    set_pass_op(32'h4040_0000);
    in_valid = 1'b1;
    cycle("post", acc);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin cycle("post", acc); n++; end
    check_val("post_latency", 32'(n), 32'(DP_LATENCY + 1));
    check_val("post_value", out_data, 32'h4040_0000);
    run("post", 3, 1'b0);

`ifdef FP_RESULT_EXC_EN
    // +Inf + -Inf -> NaN
    op_a = 32'h7F80_0000; op_b = 32'hFF80_0000; op_c = 32'h3F80_0000; op_d = 32'h0000_0000;
    in_valid = 1'b1;
    cycle("exc_nan", acc);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin cycle("exc_nan", acc); n++; end
    check_val("exc_nan_value", out_data, FP_QNAN);
    check_val("exc_nan_class", 32'(out_exc), 32'd2);
    run("exc_nan", 2, 1'b0);
    // Overflow to +Inf
    op_a = 32'h7F00_0000; op_b = 32'h7F00_0000; op_c = 32'h4000_0000; op_d = 32'h0000_0000;
    in_valid = 1'b1;
    cycle("exc_inf", acc);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin cycle("exc_inf", acc); n++; end
    check_val("exc_inf_value", out_data, 32'h7F80_0000);
    check_val("exc_inf_class", 32'(out_exc), 32'd1);
    run("exc_inf", 2, 1'b0);
    check_val("exc_after_class", 32'(out_exc), 32'd0);
`endif

    check_val("final_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
